// File: rtl/memcheck_pkg.sv
// Shared types and constants for the memcheck stream checker.
package memcheck_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [31:0] NO_ERR_IDX = 32'hFFFF_FFFF;

endpackage

// File: rtl/byte_mismatch_cnt.sv
// Combinational count of byte lanes in a beat that differ from a pattern byte.
module byte_mismatch_cnt #(
  parameter int DATA_WIDTH = 512,
  parameter int MW = $clog2(DATA_WIDTH/8) + 1
) (
  input  logic [DATA_WIDTH-1:0] beat_i,
  input  logic [7:0]            pat_i,
  output logic [MW-1:0]         cnt_o
);

  localparam int NB = DATA_WIDTH / 8;

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < NB; i++) begin
      cnt_o = cnt_o + MW'(beat_i[i*8 +: 8] != pat_i);
    end
  end

endmodule

// File: rtl/memcheck_stream.sv
// Streaming memory checker: compares each beat against a pattern byte.
// Optional first-mismatch index tracking: MEMCHECK_FIRST_ERR_EN.
module memcheck_stream
  import memcheck_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ext_data_i_valid,
  output logic                  ext_data_i_ready,
  input  logic [DATA_WIDTH-1:0] ext_data_i_bits,
  input  logic [31:0]           ext_csr_i_0,
  input  logic [31:0]           ext_csr_i_1,
  input  logic                  ext_start_i,
  output logic                  ext_busy_o,
  output logic                  ext_done_o,
  output logic [31:0]           ext_csr_o_0,
  output logic [31:0]           ext_csr_o_1
);

  localparam int MW = $clog2(DATA_WIDTH/8) + 1;

  state_e               state_q, state_d;
  logic [7:0]           pat_q, pat_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] idx_q, idx_d;
  logic [CNT_WIDTH-1:0] err_q, err_d;
  logic                 done_q, done_d;

  logic [MW-1:0]        mm;
  logic [CNT_WIDTH:0]   sum;
  logic [CNT_WIDTH-1:0] cnt_in;
  logic                 acc;
  logic                 last;
  logic                 start_ok;
  logic                 unused_csr;

  byte_mismatch_cnt #(
    .DATA_WIDTH(DATA_WIDTH),
    .MW        (MW)
  ) u_mm (
    .beat_i(ext_data_i_bits),
    .pat_i (pat_q),
    .cnt_o (mm)
  );

  assign unused_csr       = ^{ext_csr_i_0, ext_csr_i_1};
  assign cnt_in           = ext_csr_i_1[CNT_WIDTH-1:0];
  assign ext_data_i_ready = (state_q == RUN);
  assign ext_busy_o       = (state_q == RUN);
  assign ext_done_o       = done_q;
  assign ext_csr_o_0      = 32'(err_q);
  assign acc              = ext_data_i_valid && ext_data_i_ready;
  assign last             = (idx_q == cnt_q - CNT_WIDTH'(1));
  assign start_ok         = (state_q == IDLE) && ext_start_i;
  // One extra bit catches overflow for saturation
  assign sum              = {1'b0, err_q} + (CNT_WIDTH+1)'(mm);

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    err_d   = err_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ext_start_i) begin
          err_d = '0;
          idx_d = '0;
          if (cnt_in == '0) begin
            done_d = 1'b1;
          end else begin
            pat_d   = ext_csr_i_0[7:0];
            cnt_d   = cnt_in;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (acc) begin
          err_d = sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
          idx_d = idx_q + CNT_WIDTH'(1);
          if (last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      err_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

`ifdef MEMCHECK_FIRST_ERR_EN
  logic [31:0] first_q, first_d;

  always_comb begin
    first_d = first_q;
    if (start_ok) begin
      first_d = NO_ERR_IDX;
    end else if (acc && (mm != '0) && (first_q == NO_ERR_IDX)) begin
      first_d = 32'(idx_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_q <= NO_ERR_IDX;
    end else begin
      first_q <= first_d;
    end
  end

  assign ext_csr_o_1 = first_q;
`else
  logic unused_start;
  assign unused_start = start_ok;
  assign ext_csr_o_1  = NO_ERR_IDX;
`endif

endmodule

// File: tb/tb_memcheck_stream.sv
// Directed self-checking bench for memcheck_stream (32- and 8-bit counters).
module tb_memcheck_stream;

  localparam int DW = 512;

`ifdef MEMCHECK_FIRST_ERR_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          valid;
  logic [DW-1:0] bits;
  logic [31:0]   csr_i_0;
  logic [31:0]   csr_i_1;
  logic          start;

  logic          ready, busy, done;
  logic [31:0]   c0, c1;
  logic          ready8, busy8, done8;
  logic [31:0]   c0_8, c1_8;

  int n_chk;
  int n_pass;
  int acc_cnt;
  int done_cnt;

  memcheck_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(32)) u_dut (
    .clk             (clk),
    .rst             (rst),
    .ext_data_i_valid(valid),
    .ext_data_i_ready(ready),
    .ext_data_i_bits (bits),
    .ext_csr_i_0     (csr_i_0),
    .ext_csr_i_1     (csr_i_1),
    .ext_start_i     (start),
    .ext_busy_o      (busy),
    .ext_done_o      (done),
    .ext_csr_o_0     (c0),
    .ext_csr_o_1     (c1)
  );

  memcheck_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(8)) u_dut8 (
    .clk             (clk),
    .rst             (rst),
    .ext_data_i_valid(valid),
    .ext_data_i_ready(ready8),
    .ext_data_i_bits (bits),
    .ext_csr_i_0     (csr_i_0),
    .ext_csr_i_1     (csr_i_1),
    .ext_start_i     (start),
    .ext_busy_o      (busy8),
    .ext_done_o      (done8),
    .ext_csr_o_0     (c0_8),
    .ext_csr_o_1     (c1_8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (valid && ready) acc_cnt++;
    if (done) done_cnt++;
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  function automatic logic [31:0] exp_idx(input int i);
    return FE ? 32'(i) : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [DW-1:0] fill(input logic [7:0] b);
    return {(DW/8){b}};
  endfunction

  // Starts a check; afterwards scrambles the CSRs to prove they were latched.
  task automatic start_chk(input logic [7:0] pat, input int cnt);
    @(negedge clk);
    csr_i_0 = {24'h0, pat};
    csr_i_1 = cnt;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    csr_i_0 = {24'h0, ~pat};
    csr_i_1 = 32'd1;
  endtask

  // Presents one beat from the current negedge until it is accepted.
  task automatic push(input logic [DW-1:0] b);
    bit ok;
    ok    = 1'b0;
    valid = 1'b1;
    bits  = b;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("push_timeout", 0, 1);
    @(negedge clk);
    valid = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] b;
    int            a0;
    int            d0;

    n_chk = 0; n_pass = 0; acc_cnt = 0; done_cnt = 0;
    rst = 1'b1; valid = 1'b0; bits = '0;
    csr_i_0 = '0; csr_i_1 = '0; start = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_ready", ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_c0", c0, 0);
    check("rst_c1", c1, 32'hFFFF_FFFF);
    rst = 1'b0;

    // All-match run
    start_chk(8'hA5, 4);
    check("t1_busy", busy, 1);
    check("t1_ready", ready, 1);
    for (int k = 0; k < 4; k++) push(fill(8'hA5));
    check("t1_done", done, 1);
    check("t1_idle_ready", ready, 0);
    check("t1_c0", c0, 0);
    check("t1_c1", c1, 32'hFFFF_FFFF);
    @(negedge clk);
    check("t1_done_1cyc", done, 0);

    // Two bad bytes in beat 1
    start_chk(8'h00, 3);
    push(fill(8'h00));
    check("t2_c0_b0", c0, 0);
    b = fill(8'h00);
    b[5*8 +: 8]  = 8'h01;
    b[63*8 +: 8] = 8'h01;
    push(b);
    check("t2_c0_b1", c0, 2);
    check("t2_notdone", done, 0);
    push(fill(8'h00));
    check("t2_done", done, 1);
    check("t2_c0", c0, 2);
    check("t2_c1", c1, exp_idx(1));

    // Zero-count start
    repeat (2) @(negedge clk);
    d0 = done_cnt;
    csr_i_1 = 0;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t3_done", done, 1);
    check("t3_ready", ready, 0);
    check("t3_busy", busy, 0);
    check("t3_c0", c0, 0);
    check("t3_c1", c1, 32'hFFFF_FFFF);
    @(negedge clk);
    check("t3_done_1cyc", done, 0);
    check("t3_done_cnt", done_cnt - d0, 1);

    // Count 8 with valid gaps and an ignored mid-run start
    a0 = acc_cnt;
    d0 = done_cnt;
    start_chk(8'h3C, 8);
    for (int k = 0; k < 8; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if (k == 4) begin
        csr_i_1 = 2;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      b = fill(8'h3C);
      for (int j = 0; j < k; j++) b[j*8 +: 8] = 8'hC3;
      push(b);
    end
    repeat (4) @(negedge clk);
    check("t4_accepted", acc_cnt - a0, 8);
    check("t4_dones", done_cnt - d0, 1);
    check("t4_busy", busy, 0);
    check("t4_c0", c0, 28);
    check("t4_c1", c1, exp_idx(1));

    // Saturation on the 8-bit counter instance
    start_chk(8'h00, 5);
    for (int k = 0; k < 3; k++) push(fill(8'hFF));
    check("t5_c0_8_192", c0_8, 192);
    push(fill(8'hFF));
    check("t5_c0_8_sat4", c0_8, 255);
    push(fill(8'hFF));
    check("t5_done8", done8, 1);
    check("t5_c0_8", c0_8, 255);
    check("t5_c0_32", c0, 320);
    check("t5_c1_8", c1_8, exp_idx(0));

    // Reset mid-run
    start_chk(8'h55, 6);
    push(fill(8'hAA));
    push(fill(8'h55));
    a0 = acc_cnt;
    d0 = done_cnt;
    rst   = 1'b1;
    valid = 1'b1;
    bits  = fill(8'h55);
    @(negedge clk);
    check("t6_ready", ready, 0);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_c0", c0, 0);
    check("t6_c1", c1, 32'hFFFF_FFFF);
    @(negedge clk);
    rst   = 1'b0;
    valid = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_no_accept", acc_cnt - a0, 0);
    check("t6_no_done", done_cnt - d0, 0);
    check("t6_idle", busy, 0);
    start_chk(8'h11, 2);
    push(fill(8'h11));
    b = fill(8'h11);
    b[7:0] = 8'h00;
    push(b);
    check("t6_new_done", done, 1);
    check("t6_new_c0", c0, 1);
    check("t6_new_c1", c1, exp_idx(1));

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/memcheck_stream.md
MEMCHECK_STREAM -- requirements
Module: memcheck_stream

Interface
REQ-001 Parameter: DATA_WIDTH, default 512, stream beat width in bits; SHALL be a multiple of 8 and at most 1024.
REQ-002 Parameter: CNT_WIDTH, default 32, width of beat counter and result counters.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 ext_data_i_valid  in  1  input beat valid.
REQ-006 ext_data_i_ready  out  1  input beat ready.
REQ-007 ext_data_i_bits  in  DATA_WIDTH  input beat, byte i at bits [i*8 +: 8].
REQ-008 ext_csr_i_0  in  32  expected pattern byte in [7:0]; [31:8] ignored.
REQ-009 ext_csr_i_1  in  32  number of beats to check, low CNT_WIDTH bits used.
REQ-010 ext_start_i  in  1  single-cycle start pulse.
REQ-011 ext_busy_o  out  1  high while a check is in progress.
REQ-012 ext_done_o  out  1  one-cycle pulse when a check completes.
REQ-013 ext_csr_o_0  out  32  count of mismatching bytes, saturating.
REQ-014 ext_csr_o_1  out  32  beat index of first mismatch, or 32'hFFFF_FFFF if there was none.

Function
REQ-015 The FSM SHALL have exactly two states, IDLE and RUN.
REQ-016 IDLE: ext_data_i_ready=0 and ext_busy_o=0.
REQ-017 On ext_start_i in IDLE with count>0, the block SHALL latch pattern and count, clear both result outputs to 0 and 32'hFFFF_FFFF, zero the beat index, and enter RUN next cycle.
REQ-018 On ext_start_i in IDLE with count==0, the block SHALL clear the results, stay in IDLE, and pulse ext_done_o next cycle.
REQ-019 RUN: ext_data_i_ready=1 and ext_busy_o=1.
REQ-020 A beat SHALL be accepted only when valid and ready are both high in the same cycle.
REQ-021 Each accepted beat: mismatches = number of byte lanes whose byte differs from the latched pattern, range 0..DATA_WIDTH/8.
REQ-022 ext_csr_o_0 SHALL add the beat's mismatches one cycle after acceptance and saturate at 2^CNT_WIDTH-1.
REQ-023 If the beat's mismatches>0 and ext_csr_o_1 is still 32'hFFFF_FFFF, ext_csr_o_1 SHALL take the current beat index.
REQ-024 The beat index SHALL increment per accepted beat; it SHALL not wrap within a check.
REQ-025 On acceptance of beat number count-1, the block SHALL return to IDLE next cycle, with ready low that cycle, and pulse ext_done_o in the same cycle as the final result update.
REQ-026 ext_start_i while in RUN SHALL be ignored; pattern and count changes after start SHALL have no effect.
REQ-027 Valid low in RUN stalls the check indefinitely; no timeout.
REQ-028 Results SHALL hold their values in IDLE until the next start.

Reset
REQ-029 On rst: state=IDLE, ready=0, busy=0, done=0, ext_csr_o_0=0, ext_csr_o_1=32'hFFFF_FFFF, beat index=0.
REQ-030 Assertion mid-RUN SHALL abort the check immediately with no done pulse; no data is consumed while rst is high.

Configuration
REQ-031 With MEMCHECK_FIRST_ERR_EN defined, the first-mismatch logic of REQ-023 SHALL be present.
REQ-032 Without MEMCHECK_FIRST_ERR_EN, ext_csr_o_1 SHALL be constant 32'hFFFF_FFFF and no index register SHALL be synthesized for it.

Structure
REQ-033 Package memcheck_pkg SHALL hold the state enum (IDLE, RUN) and the constant NO_ERR_IDX=32'hFFFF_FFFF.
REQ-034 Sub-module byte_mismatch_cnt SHALL be purely combinational: DATA_WIDTH beat plus pattern byte -> mismatch count of width $clog2(DATA_WIDTH/8)+1.

Verification
REQ-035 Pattern 0xA5, count 4, four all-0xA5 beats -> done after the 4th beat, csr_o_0=0, csr_o_1=FFFFFFFF.
REQ-036 Pattern 0x00, count 3, beat 1 has bytes 5 and 63 = 0x01 -> csr_o_0=2, csr_o_1=1.
REQ-037 Count 0 start -> no ready, done pulse next cycle, csr_o_0=0.
REQ-038 Count 8 with random valid gaps and a mid-run start pulse -> exactly 8 beats accepted and the second start is ignored.
REQ-039 CNT_WIDTH=8, count 5, all beats fully mismatched with 64 bytes each -> csr_o_0 saturates at 255.
REQ-040 rst asserted after 2 of 6 beats -> outputs return to reset values, no done pulse, and a new start works normally.
